uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready transmit FIFO, LSB-first framing.
// Define UART_PARITY_EN to add a parity bit and the parity_odd_i port.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata_i,
  input  logic                          s_axis_tvalid_i,
  output logic                          s_axis_tready_o,
  input  logic [PRESCALE_W-1:0]         prescale_i,
`ifdef UART_PARITY_EN
  input  logic                          parity_odd_i,
`endif
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic                  txd_q, txd_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
`ifdef UART_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  push, pop, start, bit_end;
  logic [DATA_WIDTH-1:0] head;
  logic [PRESCALE_W-1:0] period_new;

  assign s_axis_tready_o = (count_q != FULL);
  assign push            = s_axis_tvalid_i && s_axis_tready_o;
  assign head            = mem_q[rptr_q];
  assign bit_end         = (cnt_q == '0);
  assign period_new      = (prescale_i == '0) ? ONE : prescale_i;

  always_comb begin
    state_d  = state_q;
    txd_d    = txd_q;
    shift_d  = shift_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
`ifdef UART_PARITY_EN
    par_d    = par_q;
`endif
    start    = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? period_q - ONE : cnt_q - ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) start = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
            stop_d  = 1'b0;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next start bit when work is queued.
            if (count_q != '0) start = 1'b1;
            else state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = START;
      txd_d    = 1'b0;
      shift_d  = head;
      period_d = period_new;
      cnt_d    = period_new - ONE;
`ifdef UART_PARITY_EN
      par_d    = (^head) ^ parity_odd_i;
`endif
    end
  end

  assign pop = start;

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      txd_q    <= 1'b1;
      shift_q  <= '0;
      period_q <= ONE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q    <= 1'b0;
`endif
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
`ifdef UART_PARITY_EN
      par_q    <= par_d;
`endif
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the flushed pointers hide stale entries.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= s_axis_tdata_i;
  end

  assign txd_o        = txd_q;
  assign busy_o       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count_o = count_q;

endmodule
